// File: rtl/mem_stage.sv
// Memory-access stage: single-outstanding req/ack data bus, store lane
// steering, load alignment/extension. Optional MEM_MISALIGN_CHK_EN trap.
module mem_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            m_valid_i,
    input  logic [XLEN-1:0] m_alu_result_i,
    input  logic [XLEN-1:0] m_mem_addr_i,
    input  logic            m_mem_wen_i,
    input  logic [XLEN-1:0] m_mem_wdata_temp_i,
    input  logic            m_reg_wen_i,
    input  logic            m_reg_mux_i,
    input  logic [4:0]      m_reg_waddr_i,
    input  logic [2:0]      m_l_mux_i,
    input  logic [2:0]      m_s_mux_i,
    output logic            m_stall_o,
    output logic            m_bus_req_o,
    output logic            m_bus_we_o,
    output logic [XLEN-1:0] m_bus_addr_o,
    output logic [XLEN-1:0] m_bus_wdata_o,
    output logic [7:0]      m_bus_wstrb_o,
    input  logic            m_bus_ack_i,
    input  logic [XLEN-1:0] m_bus_rdata_i,
    output logic            m_wb_valid_o,
    output logic            m_reg_wen_o,
    output logic [4:0]      m_reg_waddr_o,
    output logic [XLEN-1:0] m_reg_wdata_o
`ifdef MEM_MISALIGN_CHK_EN
    ,
    output logic            m_misalign_o
`endif
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUS  = 1'b1;

    logic [0:0]      state_q, state_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [7:0]      wstrb_q, wstrb_d;
    logic [2:0]      off_q, off_d;
    logic [2:0]      lmux_q, lmux_d;
    logic [4:0]      lat_waddr_q, lat_waddr_d;
    logic            lat_wen_q, lat_wen_d;
    logic            store_q, store_d;
    logic            wbv_q, wbv_d;
    logic            rwen_q, rwen_d;
    logic [4:0]      rwaddr_q, rwaddr_d;
    logic [XLEN-1:0] rwdata_q, rwdata_d;
    logic            mis_q, mis_d;

    logic            mem_op;
    logic            mis_c;
    logic [2:0]      a;
    logic [7:0]      strb_c;
    logic [XLEN-1:0] wdat_c;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] ld_data;

    assign mem_op = m_valid_i & (m_mem_wen_i | m_reg_mux_i);
    assign a      = m_mem_addr_i[2:0];

    always_comb begin
        strb_c = 8'h00;
        wdat_c = '0;
        case (m_s_mux_i)
            3'b000: begin
                strb_c = 8'h01 << a;
                wdat_c = {8{m_mem_wdata_temp_i[7:0]}};
            end
            3'b001: begin
                strb_c = 8'h03 << {a[2:1], 1'b0};
                wdat_c = {4{m_mem_wdata_temp_i[15:0]}};
            end
            3'b010: begin
                strb_c = 8'h0F << {a[2], 2'b00};
                wdat_c = {2{m_mem_wdata_temp_i[31:0]}};
            end
            3'b011: begin
                strb_c = 8'hFF;
                wdat_c = m_mem_wdata_temp_i;
            end
            default: begin
                strb_c = 8'h00;
                wdat_c = '0;
            end
        endcase
    end

`ifdef MEM_MISALIGN_CHK_EN
    // Reserved codes never trap; they fall through as no-op bus accesses.
    always_comb begin
        mis_c = 1'b0;
        if (m_mem_wen_i) begin
            case (m_s_mux_i)
                3'b001:  mis_c = a[0];
                3'b010:  mis_c = |a[1:0];
                3'b011:  mis_c = |a;
                default: mis_c = 1'b0;
            endcase
        end else if (m_l_mux_i != 3'b111) begin
            case (m_l_mux_i[1:0])
                2'b01:   mis_c = a[0];
                2'b10:   mis_c = |a[1:0];
                2'b11:   mis_c = |a;
                default: mis_c = 1'b0;
            endcase
        end
    end
`else
    assign mis_c = 1'b0;
`endif

    assign shifted = m_bus_rdata_i >> {off_q, 3'b000};

    always_comb begin
        ld_data = '0;
        case (lmux_q)
            3'b000:  ld_data = {{56{shifted[7]}}, shifted[7:0]};
            3'b001:  ld_data = {{48{shifted[15]}}, shifted[15:0]};
            3'b010:  ld_data = {{32{shifted[31]}}, shifted[31:0]};
            3'b011:  ld_data = shifted;
            3'b100:  ld_data = {56'd0, shifted[7:0]};
            3'b101:  ld_data = {48'd0, shifted[15:0]};
            3'b110:  ld_data = {32'd0, shifted[31:0]};
            default: ld_data = '0;
        endcase
    end

    assign m_stall_o = mem_op
                     & ~((state_q == S_BUS) & m_bus_ack_i)
                     & ~((state_q == S_IDLE) & mis_c);

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        off_d       = off_q;
        lmux_d      = lmux_q;
        lat_waddr_d = lat_waddr_q;
        lat_wen_d   = lat_wen_q;
        store_d     = store_q;
        wbv_d       = 1'b0;
        rwen_d      = 1'b0;
        rwaddr_d    = rwaddr_q;
        rwdata_d    = rwdata_q;
        mis_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_op && !mis_c) begin
                    state_d     = S_BUS;
                    req_d       = 1'b1;
                    we_d        = m_mem_wen_i;
                    addr_d      = {m_mem_addr_i[XLEN-1:3], 3'b000};
                    wdata_d     = m_mem_wen_i ? wdat_c : '0;
                    wstrb_d     = m_mem_wen_i ? strb_c : 8'h00;
                    off_d       = a;
                    lmux_d      = m_l_mux_i;
                    lat_waddr_d = m_reg_waddr_i;
                    lat_wen_d   = m_reg_wen_i;
                    store_d     = m_mem_wen_i;
                end else if (mem_op) begin
                    wbv_d    = 1'b1;
                    mis_d    = 1'b1;
                    rwaddr_d = m_reg_waddr_i;
                    rwdata_d = '0;
                end else if (m_valid_i) begin
                    wbv_d    = 1'b1;
                    rwen_d   = m_reg_wen_i;
                    rwaddr_d = m_reg_waddr_i;
                    rwdata_d = m_alu_result_i;
                end
            end
            default: begin
                if (m_bus_ack_i) begin
                    state_d  = S_IDLE;
                    req_d    = 1'b0;
                    we_d     = 1'b0;
                    wstrb_d  = 8'h00;
                    wbv_d    = 1'b1;
                    rwen_d   = lat_wen_q & ~store_q;
                    rwaddr_d = lat_waddr_q;
                    rwdata_d = store_q ? '0 : ld_data;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= 8'h00;
            off_q       <= 3'd0;
            lmux_q      <= 3'd0;
            lat_waddr_q <= 5'd0;
            lat_wen_q   <= 1'b0;
            store_q     <= 1'b0;
            wbv_q       <= 1'b0;
            rwen_q      <= 1'b0;
            rwaddr_q    <= 5'd0;
            rwdata_q    <= '0;
            mis_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            off_q       <= off_d;
            lmux_q      <= lmux_d;
            lat_waddr_q <= lat_waddr_d;
            lat_wen_q   <= lat_wen_d;
            store_q     <= store_d;
            wbv_q       <= wbv_d;
            rwen_q      <= rwen_d;
            rwaddr_q    <= rwaddr_d;
            rwdata_q    <= rwdata_d;
            mis_q       <= mis_d;
        end
    end

    assign m_bus_req_o   = req_q;
    assign m_bus_we_o    = we_q;
    assign m_bus_addr_o  = addr_q;
    assign m_bus_wdata_o = wdata_q;
    assign m_bus_wstrb_o = wstrb_q;
    assign m_wb_valid_o  = wbv_q;
    assign m_reg_wen_o   = rwen_q;
    assign m_reg_waddr_o = rwaddr_q;
    assign m_reg_wdata_o = rwdata_q;
`ifdef MEM_MISALIGN_CHK_EN
    assign m_misalign_o  = mis_q;
`else
    logic unused_mis;
    assign unused_mis = mis_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, stores, loads,
// delayed ack, reset mid-access, reserved codes, optional misalign trap.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic [63:0] alu;
    logic [63:0] maddr;
    logic        mwen;
    logic [63:0] wtemp;
    logic        rwen;
    logic        rmux;
    logic [4:0]  waddr;
    logic [2:0]  lmux;
    logic [2:0]  smux;
    logic        stall;
    logic        req;
    logic        we;
    logic [63:0] baddr;
    logic [63:0] bwdata;
    logic [7:0]  wstrb;
    logic        ack;
    logic [63:0] rdata;
    logic        wbv;
    logic        owen;
    logic [4:0]  owaddr;
    logic [63:0] owdata;
`ifdef MEM_MISALIGN_CHK_EN
    logic        mis;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .m_valid_i          (valid),
        .m_alu_result_i     (alu),
        .m_mem_addr_i       (maddr),
        .m_mem_wen_i        (mwen),
        .m_mem_wdata_temp_i (wtemp),
        .m_reg_wen_i        (rwen),
        .m_reg_mux_i        (rmux),
        .m_reg_waddr_i      (waddr),
        .m_l_mux_i          (lmux),
        .m_s_mux_i          (smux),
        .m_stall_o          (stall),
        .m_bus_req_o        (req),
        .m_bus_we_o         (we),
        .m_bus_addr_o       (baddr),
        .m_bus_wdata_o      (bwdata),
        .m_bus_wstrb_o      (wstrb),
        .m_bus_ack_i        (ack),
        .m_bus_rdata_i      (rdata),
        .m_wb_valid_o       (wbv),
        .m_reg_wen_o        (owen),
        .m_reg_waddr_o      (owaddr),
        .m_reg_wdata_o      (owdata)
`ifdef MEM_MISALIGN_CHK_EN
        ,
        .m_misalign_o       (mis)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; valid = 1'b0; alu = '0; maddr = '0; mwen = 1'b0;
        wtemp = '0; rwen = 1'b0; rmux = 1'b0; waddr = '0; lmux = '0;
        smux = '0; ack = 1'b0; rdata = '0;
        tick(); tick();
        chk("rst_req", {63'd0, req}, 64'd0);
        chk("rst_wbv", {63'd0, wbv}, 64'd0);
        chk("rst_wen", {63'd0, owen}, 64'd0);
        chk("rst_wdata", owdata, 64'd0);
        chk("rst_baddr", baddr, 64'd0);
        chk("rst_stall", {63'd0, stall}, 64'd0);
        rst_n = 1'b1;

        // ALU op
        valid = 1'b1; rwen = 1'b1; waddr = 5'd5; alu = 64'h1234; #1;
        chk("alu_stall", {63'd0, stall}, 64'd0);
        tick();
        chk("alu_wbv", {63'd0, wbv}, 64'd1);
        chk("alu_wen", {63'd0, owen}, 64'd1);
        chk("alu_waddr", {59'd0, owaddr}, 64'd5);
        chk("alu_wdata", owdata, 64'h1234);
        chk("alu_req", {63'd0, req}, 64'd0);
        valid = 1'b0;
        tick();
        chk("idle_wbv", {63'd0, wbv}, 64'd0);
        chk("idle_wen", {63'd0, owen}, 64'd0);

        // sb
        valid = 1'b1; mwen = 1'b1; rwen = 1'b0; maddr = 64'h1003;
        wtemp = 64'hAB; smux = 3'b000; #1;
        chk("sb_stall0", {63'd0, stall}, 64'd1);
        tick();
        chk("sb_req", {63'd0, req}, 64'd1);
        chk("sb_we", {63'd0, we}, 64'd1);
        chk("sb_addr", baddr, 64'h1000);
        chk("sb_strb", {56'd0, wstrb}, 64'h08);
        chk("sb_wdata", bwdata, 64'hABAB_ABAB_ABAB_ABAB);
        chk("sb_wbv0", {63'd0, wbv}, 64'd0);
        ack = 1'b1; #1;
        chk("sb_stall1", {63'd0, stall}, 64'd0);
        tick();
        chk("sb_req_drop", {63'd0, req}, 64'd0);
        chk("sb_wbv", {63'd0, wbv}, 64'd1);
        chk("sb_wen", {63'd0, owen}, 64'd0);
        ack = 1'b0; valid = 1'b0; mwen = 1'b0;

        // lh then lhu
        valid = 1'b1; rmux = 1'b1; rwen = 1'b1; waddr = 5'd7;
        maddr = 64'h2006; lmux = 3'b001;
        tick();
        chk("lh_req", {63'd0, req}, 64'd1);
        chk("lh_we", {63'd0, we}, 64'd0);
        chk("lh_strb", {56'd0, wstrb}, 64'd0);
        chk("lh_addr", baddr, 64'h2000);
        ack = 1'b1; rdata = 64'h8001_0000_0000_0000;
        tick();
        chk("lh_wbv", {63'd0, wbv}, 64'd1);
        chk("lh_wen", {63'd0, owen}, 64'd1);
        chk("lh_waddr", {59'd0, owaddr}, 64'd7);
        chk("lh_wdata", owdata, 64'hFFFF_FFFF_FFFF_8001);
        ack = 1'b0; lmux = 3'b101;
        tick();
        chk("lhu_req", {63'd0, req}, 64'd1);
        ack = 1'b1;
        tick();
        chk("lhu_wdata", owdata, 64'h0000_0000_0000_8001);
        ack = 1'b0; valid = 1'b0;

        // lw with 3-cycle ack delay
        valid = 1'b1; maddr = 64'h3004; lmux = 3'b010; waddr = 5'd9;
        rdata = 64'h8765_4321_0000_0000;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("lw_req_hold", {63'd0, req}, 64'd1);
            chk("lw_addr_hold", baddr, 64'h3000);
            chk("lw_stall", {63'd0, stall}, 64'd1);
            chk("lw_wbv_wait", {63'd0, wbv}, 64'd0);
            tick();
        end
        ack = 1'b1; #1;
        chk("lw_stall_ack", {63'd0, stall}, 64'd0);
        tick();
        chk("lw_wbv", {63'd0, wbv}, 64'd1);
        chk("lw_wdata", owdata, 64'hFFFF_FFFF_8765_4321);
        ack = 1'b0; valid = 1'b0;
        tick();
        chk("lw_single_wb", {63'd0, wbv}, 64'd0);
        chk("lw_req_idle", {63'd0, req}, 64'd0);

        // reset while in BUS
        valid = 1'b1; maddr = 64'h5008; lmux = 3'b011;
        tick();
        chk("rb_req", {63'd0, req}, 64'd1);
        rst_n = 1'b0;
        tick();
        chk("rb_req0", {63'd0, req}, 64'd0);
        chk("rb_wbv0", {63'd0, wbv}, 64'd0);
        rst_n = 1'b1; valid = 1'b0; ack = 1'b1;
        tick();
        chk("rb_late_ack", {63'd0, wbv}, 64'd0);
        chk("rb_req_idle", {63'd0, req}, 64'd0);
        ack = 1'b0;

        // reserved load code
        valid = 1'b1; maddr = 64'h6000; lmux = 3'b111;
        rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        chk("rsv_req", {63'd0, req}, 64'd1);
        ack = 1'b1;
        tick();
        chk("rsv_wbv", {63'd0, wbv}, 64'd1);
        chk("rsv_wdata", owdata, 64'd0);
        ack = 1'b0; valid = 1'b0;

        // sd at misaligned address (ignored low bits), then sh at ...7
`ifndef MEM_MISALIGN_CHK_EN
        valid = 1'b1; rmux = 1'b0; mwen = 1'b1; rwen = 1'b0;
        maddr = 64'h7005; smux = 3'b011; wtemp = 64'h1122_3344_5566_BEEF;
        tick();
        chk("sd_addr", baddr, 64'h7000);
        chk("sd_strb", {56'd0, wstrb}, 64'hFF);
        chk("sd_wdata", bwdata, 64'h1122_3344_5566_BEEF);
        ack = 1'b1;
        tick();
        ack = 1'b0; maddr = 64'h7007; smux = 3'b001;
        tick();
        chk("sh_strb", {56'd0, wstrb}, 64'hC0);
        chk("sh_wdata", bwdata, 64'hBEEF_BEEF_BEEF_BEEF);
        ack = 1'b1;
        tick();
        chk("sh_wbv", {63'd0, wbv}, 64'd1);
        ack = 1'b0; valid = 1'b0; mwen = 1'b0;
`else
        valid = 1'b1; rmux = 1'b0; mwen = 1'b1; rwen = 1'b1;
        maddr = 64'h4002; smux = 3'b010; wtemp = 64'h55; #1;
        chk("mis_stall", {63'd0, stall}, 64'd0);
        tick();
        chk("mis_req", {63'd0, req}, 64'd0);
        chk("mis_pulse", {63'd0, mis}, 64'd1);
        chk("mis_wbv", {63'd0, wbv}, 64'd1);
        chk("mis_wen", {63'd0, owen}, 64'd0);
        valid = 1'b0; mwen = 1'b0;
        tick();
        chk("mis_pulse_end", {63'd0, mis}, 64'd0);
        chk("mis_req_idle", {63'd0, req}, 64'd0);
`endif

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute stage; consumes its ALU result, memory address, store data, load/store selects and register-writeback controls.
- Performs load/store accesses over a single-outstanding req/ack data bus.
- Produces byte strobes and replicated write data for stores; aligns and sign/zero-extends load data.
- Registers the writeback bundle for the writeback stage and stalls upstream while an access is in flight.

Parameters:
- XLEN, 64, datapath width; only 64 is supported.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- m_valid_i  in  1  instruction present from execute
- m_alu_result_i  in  64  ALU result (non-load writeback data)
- m_mem_addr_i  in  64  byte address of the access
- m_mem_wen_i  in  1  store instruction
- m_mem_wdata_temp_i  in  64  raw store data (rs2)
- m_reg_wen_i  in  1  register write enable
- m_reg_mux_i  in  1  1 = load (writeback from memory), 0 = ALU result
- m_reg_waddr_i  in  5  destination register
- m_l_mux_i  in  3  load type: 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu
- m_s_mux_i  in  3  store type: 000 sb, 001 sh, 010 sw, 011 sd
- m_stall_o  out  1  upstream must hold its inputs
- m_bus_req_o  out  1  bus request
- m_bus_we_o  out  1  1 = write
- m_bus_addr_o  out  64  doubleword-aligned address ({addr[63:3], 3'b0})
- m_bus_wdata_o  out  64  lane-replicated write data
- m_bus_wstrb_o  out  8  byte strobes (0 on reads)
- m_bus_ack_i  in  1  access complete; rdata valid this cycle
- m_bus_rdata_i  in  64  read doubleword
- m_wb_valid_o  out  1  writeback bundle valid
- m_reg_wen_o  out  1  to writeback
- m_reg_waddr_o  out  5  to writeback
- m_reg_wdata_o  out  64  to writeback

Behaviour:
- Memory op: mem_op = m_valid_i & (m_mem_wen_i | m_reg_mux_i).
- Reset (sync, rst_n = 0): state IDLE; every registered output is 0 (bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb, wb_valid, reg_wen, reg_waddr, reg_wdata). Reset mid-access abandons the access: req drops on the next edge and no writeback is produced; any ack arriving after reset is ignored.
- FSM has two states, IDLE and BUS.
- IDLE, non-memory op (m_valid_i = 1, mem_op = 0): next cycle wb_valid = 1, reg_wen = m_reg_wen_i, reg_wdata = m_alu_result_i. Latency is 1 cycle and no stall.
- IDLE, m_valid_i = 0: next cycle wb_valid = 0 and reg_wen = 0.
- IDLE, mem op: latch addr[2:0], l_mux, waddr, reg_wen and the store flag. Drive bus_req = 1, bus_addr, bus_we, bus_wdata and bus_wstrb as registered outputs. Go to BUS. wb_valid = 0 next cycle.
- BUS: bus_req and all bus outputs held stable until ack. On ack, req drops the next cycle, the writeback is registered (store: wb_valid = 1, reg_wen = 0) and the FSM returns to IDLE. Ack is ignored in IDLE.
- Memory-op latency: 2 cycles minimum (accept cycle, plus ack in the first BUS cycle); writeback appears the cycle after ack.
- m_stall_o is combinational: mem_op & ~(state == BUS & m_bus_ack_i). Upstream advances on the ack cycle, so the next instruction is sampled in IDLE on the following edge.
- Store strobes: sb 8'h01 << a; sh 8'h03 << {a[2:1], 1'b0}; sw 8'h0F << {a[2], 2'b0}; sd 8'hFF; where a = addr[2:0].
- Store data: sb {8{d[7:0]}}, sh {4{d[15:0]}}, sw {2{d[31:0]}}, sd d.
- Load data: shift rdata right by addr[2:0]*8, then extend per l_mux (sign-extend lb/lh/lw; zero-extend lbu/lhu/lwu; ld taken as is).
- Misaligned addresses without the optional feature: low address bits below the access size are ignored (sh at addr ...7 uses lanes 6–7; ld at ...5 reads the whole doubleword).
- Reserved l_mux/s_mux codes: treated as a no-op access; completes via the bus with strobe 0 and writes back 0.

Optional Feature:
- Macro MEM_MISALIGN_CHK_EN.
- When defined: adds output m_misalign_o (1 bit, reset 0). A mem op with misaligned address (h: a[0] != 0; w: a[1:0] != 0; d: a[2:0] != 0) issues no bus request and causes no stall. The next cycle gives m_misalign_o = 1 for one cycle, wb_valid = 1 and reg_wen = 0.
- When not defined: port absent; behaviour as stated under Behaviour.

Test Plan:
- ALU op: waddr = 5, alu_result = 64'h1234, reg_wen = 1 -> next cycle wb_valid = 1, reg_wen = 1, waddr = 5, wdata = 64'h1234, stall never 1.
- sb addr 64'h1003, d = 64'hAB, ack on first BUS cycle -> bus_addr = 64'h1000, wstrb = 8'h08, wdata = 64'hABAB_ABAB_ABAB_ABAB; stall high for 1 cycle; writeback reg_wen = 0.
- lh addr 64'h2006, rdata = 64'h8001_0000_0000_0000 -> wdata = 64'hFFFF_FFFF_FFFF_8001; lhu at the same address -> 64'h0000_0000_0000_8001.
- lw addr 64'h3004 with ack delayed 3 cycles -> req and bus outputs stable for 3 cycles; stall = 1 until the ack cycle; single writeback the cycle after ack.
- rst_n driven low while in BUS -> next cycle req = 0 and wb_valid = 0; an ack arriving one cycle later yields no writeback.
- With MEM_MISALIGN_CHK_EN, sw addr 64'h4002 -> no req, m_misalign_o pulses 1 cycle, wb_valid = 1, reg_wen = 0.
